fib_seq_param: RTL and testbench

- Parametrised iterative Fibonacci engine. Successor to the fixed 32-bit fib block.
- Keeps the same caller handshake (fib_ready / fib_valid / fib_accept), so existing callers drive it unchanged.
- Adds configurable result and operand widths, overflow detection, a busy indication and back-to-back operation.
- Sits as a leaf compute unit under a msgpack/RPC wrapper or driven directly by a testbench.

---
 rtl/fib_seq_param.sv | 142 ++++++++++++++
 tb/tb_fib_seq_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : fib_seq_param
// Brief    : Iterative Fibonacci engine, parametrised width, overflow tag.
//            Define FIB_SATURATE_EN to clamp overflowed results to all-ones.
// Revision : 1.0
// ============================================================================
module fib_seq_param #(
    parameter int WIDTH   = 32,
    parameter int N_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fib_ready,
    input  logic               fib_accept,
    input  logic [N_WIDTH-1:0] fib_in_n,
    output logic               fib_valid,
    output logic [WIDTH-1:0]   fib_out_0,
    output logic               fib_ovf,
    output logic               fib_busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_a, r_b, w_a_nxt, w_b_nxt;
    logic               r_a_ovf, r_b_ovf, w_a_ovf_nxt, w_b_ovf_nxt;
    logic [N_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_out, w_out_nxt;
    logic               r_ovf, w_ovf_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_busy, w_busy_nxt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_result;
    logic               w_start;

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

`ifdef FIB_SATURATE_EN
    assign w_result = r_a_ovf ? {WIDTH{1'b1}} : r_a;
`else
    assign w_result = r_a;
`endif

    // A start is taken from IDLE, or from DONE when the result is consumed at the same edge.
    assign w_start = fib_ready &&
                     ((r_state == c_IDLE) || ((r_state == c_DONE) && fib_accept));

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_a_ovf_nxt = r_a_ovf;
        w_b_ovf_nxt = r_b_ovf;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_ovf_nxt   = r_ovf;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;

        case (r_state)
            c_IDLE: begin
            end
            c_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_DONE;
                    w_out_nxt   = w_result;
                    w_ovf_nxt   = r_a_ovf;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    // Overflow only becomes visible once the wrapped value shifts into a.
                    w_a_nxt     = r_b;
                    w_b_nxt     = w_sum[WIDTH-1:0];
                    w_a_ovf_nxt = r_b_ovf;
                    w_b_ovf_nxt = w_sum[WIDTH] | r_a_ovf | r_b_ovf;
                    w_cnt_nxt   = r_cnt - N_WIDTH'(1);
                end
            end
            c_DONE: begin
                if (fib_accept) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase

        if (w_start) begin
            w_state_nxt = c_CALC;
            w_cnt_nxt   = fib_in_n;
            w_a_nxt     = '0;
            w_b_nxt     = WIDTH'(1);
            w_a_ovf_nxt = 1'b0;
            w_b_ovf_nxt = 1'b0;
            w_busy_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= WIDTH'(1);
            r_a_ovf <= 1'b0;
            r_b_ovf <= 1'b0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_a_ovf <= w_a_ovf_nxt;
            r_b_ovf <= w_b_ovf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_ovf   <= w_ovf_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign fib_valid = r_valid;
    assign fib_out_0 = r_out;
    assign fib_ovf   = r_ovf;
    assign fib_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fib_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_seq_param
// Brief    : Self-checking bench for fib_seq_param at WIDTH=32 and WIDTH=8.
// Revision : 1.0
// ============================================================================
module tb_fib_seq_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fib_ready = 1'b0;
    logic        fib_accept = 1'b0;
    logic [7:0]  fib_in_n = 8'd0;

    logic        v32, ovf32, b32;
    logic [31:0] out32;
    logic        v8, ovf8, b8;
    logic [7:0]  out8;

    int errors = 0;
    int checks = 0;
    int exp_n  = 0;

    always #5 clk = ~clk;

    fib_seq_param #(.WIDTH(32), .N_WIDTH(8)) u_dut32 (
        .clk(clk), .rst(rst), .fib_ready(fib_ready), .fib_accept(fib_accept),
        .fib_in_n(fib_in_n), .fib_valid(v32), .fib_out_0(out32),
        .fib_ovf(ovf32), .fib_busy(b32)
    );

    fib_seq_param #(.WIDTH(8), .N_WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .fib_ready(fib_ready), .fib_accept(fib_accept),
        .fib_in_n(fib_in_n), .fib_valid(v8), .fib_out_0(out8),
        .fib_ovf(ovf8), .fib_busy(b8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // True Fib(n) in 64 bits is exact up to n=93; beyond that it exceeds any tested width.
    function automatic void fib_model(input int n, input int w,
                                      output logic [63:0] val, output bit ovf);
        longint unsigned a = 0, b = 1, t;
        logic [63:0] mask;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        mask = (64'd1 << w) - 64'd1;
        ovf  = (n > 93) || (a > mask);
        val  = a & mask;
`ifdef FIB_SATURATE_EN
        if (ovf) val = mask;
`endif
    endfunction

    always @(negedge clk) begin
        logic [63:0] ev;
        bit          eo;
        if (!rst) begin
            chk("valid_agree", {63'd0, v8}, {63'd0, v32});
            chk("busy_valid_excl", {63'd0, b32 & v32}, 64'd0);
            if (v32) begin
                fib_model(exp_n, 32, ev, eo);
                chk("model_out32", {32'd0, out32}, ev);
                chk("model_ovf32", {63'd0, ovf32}, {63'd0, eo});
            end
            if (v8) begin
                fib_model(exp_n, 8, ev, eo);
                chk("model_out8", {56'd0, out8}, ev);
                chk("model_ovf8", {63'd0, ovf8}, {63'd0, eo});
            end
        end
    end

    task automatic drive_start(input logic [7:0] n, input bit with_accept);
        @(negedge clk);
        fib_ready  = 1'b1;
        fib_in_n   = n;
        fib_accept = with_accept;
        @(posedge clk);
        exp_n = int'(n);
        #1;
        fib_ready  = 1'b0;
        fib_accept = 1'b0;
        fib_in_n   = 8'($urandom);
    endtask

    // Counts edges from the start edge until fib_valid; optionally pokes a stray request mid-CALC.
    task automatic wait_result(input int n, input int pulse_at);
        int edges = 0;
        bit seen  = 1'b0;
        chk("busy_after_start", {63'd0, b32}, 64'd1);
        while (!seen && edges < n + 20) begin
            if (edges == pulse_at) begin
                @(negedge clk);
                fib_ready = 1'b1;
                fib_in_n  = 8'd5;
            end
            @(posedge clk);
            #1;
            fib_ready = 1'b0;
            edges++;
            if (v32) seen = 1'b1;
        end
        chk("latency", seen ? 64'(edges) : 64'd0, 64'(n + 1));
    endtask

    task automatic do_accept();
        @(negedge clk);
        fib_accept = 1'b1;
        @(posedge clk);
        #1;
        fib_accept = 1'b0;
        chk("valid_after_accept", {63'd0, v32}, 64'd0);
        chk("busy_after_accept", {63'd0, b32}, 64'd0);
    endtask

    task automatic run(input logic [7:0] n);
        drive_start(n, 1'b0);
        wait_result(int'(n), -1);
    endtask

    initial begin
        #900_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          seq_n  [6] = '{0, 1, 2, 3, 8, 47};
        logic [63:0] seq_v  [6] = '{0, 1, 1, 2, 21, 64'd2971215073};
        logic [7:0]  rn;
        bit          pending;

        #100;
        chk("rst_valid32", {63'd0, v32}, 64'd0);
        chk("rst_out32", {32'd0, out32}, 64'd0);
        chk("rst_ovf32", {63'd0, ovf32}, 64'd0);
        chk("rst_busy32", {63'd0, b32}, 64'd0);
        chk("rst_valid8", {63'd0, v8}, 64'd0);
        chk("rst_out8", {56'd0, out8}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Abort mid-computation with an asynchronous reset.
        drive_start(8'd3, 1'b0);
        @(posedge clk);
        #2;
        chk("busy_mid_calc", {63'd0, b32}, 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {63'd0, b32}, 64'd0);
        chk("abort_valid", {63'd0, v32}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("abort_no_result", {63'd0, v32}, 64'd0);
        end
        run(8'd3);
        chk("after_abort_out", {32'd0, out32}, 64'd2);
        do_accept();

        foreach (seq_n[i]) begin
            run(8'(seq_n[i]));
            chk("seq_out32", {32'd0, out32}, seq_v[i]);
            chk("seq_ovf32", {63'd0, ovf32}, 64'd0);
            do_accept();
        end

        run(8'd13);
        chk("w8_n13_out", {56'd0, out8}, 64'd233);
        chk("w8_n13_ovf", {63'd0, ovf8}, 64'd0);
        do_accept();
        run(8'd14);
`ifdef FIB_SATURATE_EN
        chk("w8_n14_out", {56'd0, out8}, 64'd255);
`else
        chk("w8_n14_out", {56'd0, out8}, 64'd121);
`endif
        chk("w8_n14_ovf", {63'd0, ovf8}, 64'd1);
        do_accept();

        // Back-to-back: accept and new start on the same edge.
        run(8'd8);
        chk("b2b_first", {32'd0, out32}, 64'd21);
        drive_start(8'd2, 1'b1);
        chk("b2b_valid_drop", {63'd0, v32}, 64'd0);
        wait_result(2, -1);
        chk("b2b_second", {32'd0, out32}, 64'd1);
        do_accept();

        // Stray request during CALC, then a long un-accepted DONE with stray requests.
        drive_start(8'd8, 1'b0);
        wait_result(8, 3);
        chk("ignore_calc_out", {32'd0, out32}, 64'd21);
        repeat (20) begin
            @(negedge clk);
            fib_ready = 1'($urandom_range(0, 1));
            fib_in_n  = 8'($urandom);
            @(posedge clk);
            #1;
            chk("hold_valid", {63'd0, v32}, 64'd1);
            chk("hold_out32", {32'd0, out32}, 64'd21);
            chk("hold_out8", {56'd0, out8}, 64'd21);
        end
        fib_ready = 1'b0;
        do_accept();

        // Accept while idle must not disturb anything.
        repeat (3) begin
            @(negedge clk);
            fib_accept = 1'b1;
            @(posedge clk);
            #1;
            chk("idle_accept_valid", {63'd0, v32}, 64'd0);
            chk("idle_accept_busy", {63'd0, b32}, 64'd0);
        end
        fib_accept = 1'b0;
        run(8'd5);
        chk("after_idle_accept", {32'd0, out32}, 64'd5);
        do_accept();

        run(8'd255);
        chk("max_n_ovf32", {63'd0, ovf32}, 64'd1);
        do_accept();

        pending = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rn = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(0, 50));
            if (pending && ($urandom_range(0, 1) == 1)) begin
                drive_start(rn, 1'b1);
                chk("rand_b2b_drop", {63'd0, v32}, 64'd0);
            end else begin
                if (pending) do_accept();
                repeat ($urandom_range(0, 2)) @(posedge clk);
                drive_start(rn, 1'b0);
            end
            wait_result(int'(rn), -1);
            pending = 1'b1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        do_accept();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
